intersection_ctrl: RTL and testbench
====================================

# intersection_ctrl

Phase sequencer for a two-road intersection. It drives the main-road and side-road green/yellow/red lamps and a pedestrian walk lamp from one free-running tick prescaler and one phase timer. Main road rests in green; the controller cycles to the side road only on a side-road vehicle request or a latched pedestrian request. It sits above the single-road light block and replaces free-running light sequencing wherever two lamp sets must be interlocked.

## Interface
- TICK_DIV, 50_000_000: clk cycles per timing tick (≥1).
- T_MG_MIN, 30: minimum main-green duration in ticks (≥1).
- T_Y, 3: yellow duration in ticks, both roads (≥1).
- T_AR, 2: all-red clearance in ticks (≥1).
- T_SG, 15: side-green duration in ticks (≥1).
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- side_req  in  1  side-road vehicle sensor, level, sampled on tick.
- ped_req  in  1  pedestrian button, ≥1-cycle pulse, sampled every clk.
- main_green, main_yellow, main_red  out  1 each  main-road lamps.
- side_green, side_yellow, side_red  out  1 each  side-road lamps.
- walk  out  1  pedestrian walk lamp for crossing the main road.
- ped_pending  out  1  pedestrian request latched, not yet served.
- phase  out  3  current state encoding: MAIN_G=0, MAIN_Y=1, ALL_R1=2, SIDE_G=3, SIDE_Y=4, ALL_R2=5.

## Operation
- Prescaler `cnt`: counts 0..TICK_DIV-1 and wraps. It is free-running and is never cleared by phase changes. `tick`=1 exactly in cycles where cnt==TICK_DIV-1.
- Phase timer `tmr` counts ticks spent in the current state:
  - cleared to 0 on every state change;
  - otherwise incremented on tick;
  - in MAIN_G it saturates at T_MG_MIN-1.
- Transitions are evaluated only in tick cycles:
  - MAIN_G→MAIN_Y when tmr==T_MG_MIN-1 and (side_req or ped_pending). Otherwise stay in MAIN_G indefinitely.
  - MAIN_Y→ALL_R1 when tmr==T_Y-1.
  - ALL_R1→SIDE_G when tmr==T_AR-1.
  - SIDE_G→SIDE_Y when tmr==T_SG-1. side_req does not extend the phase.
  - SIDE_Y→ALL_R2 when tmr==T_Y-1.
  - ALL_R2→MAIN_G when tmr==T_AR-1.
- Unused encodings 6 and 7 go to ALL_R2 on the next clk, regardless of tick.
- Outputs are a Moore decode of the registered state:
  - main road: green in MAIN_G, yellow in MAIN_Y, red otherwise;
  - side road: green in SIDE_G, yellow in SIDE_Y, red otherwise;
  - walk=1 only in SIDE_G.
  - Exactly one lamp per road is lit. Both roads are never non-red at the same time.
- ped_pending:
  - set by ped_req in any cycle where the state is not SIDE_G;
  - cleared in the cycle the state register becomes SIDE_G;
  - ped_req while in SIDE_G is ignored.
- Simultaneous events: if ped_req arrives in the same cycle as the ALL_R1→SIDE_G update, clear wins and the request is served by the walk now starting.
- Reset (any cycle, mid-phase included), on the next edge:
  - state=MAIN_G, tmr=0, cnt=0, ped_pending=0;
  - outputs main_green=1, side_red=1, all others 0, phase=0.

## Timing
- Cycle numbering: cycle 0 is the first edge with rst low.
- Ticks fall in cycles TICK_DIV-1, 2·TICK_DIV-1, …
- The state update is visible on outputs one cycle after the deciding tick.
- Every phase lasts exactly T·TICK_DIV cycles, because transitions are tick-aligned. The exception is MAIN_G, which extends in whole-tick steps until a request is present.
- Request latency: a request first seen after min-green has expired moves main to yellow within TICK_DIV cycles (next tick + 1 cycle).
- With TICK_DIV=1, tick is constant 1 and all durations are in cycles.

## Test plan
All scenarios use TICK_DIV=4, T_MG_MIN=3, T_Y=2, T_AR=1, T_SG=4, except the reset check.

- Reset: hold rst high for 3 cycles, then release → main_green=1, side_red=1, walk=0, ped_pending=0, phase=0 from the first post-reset cycle.
- Idle: no requests for 1000 cycles → stays in MAIN_G with phase=0 throughout; lamp outputs never toggle.
- Vehicle cycle: side_req=1 over cycles 0..23, then 0. Required phase sequence:
  - MAIN_Y at cycle 12, ALL_R1 at 20, SIDE_G at 24, SIDE_Y at 40, ALL_R2 at 48, MAIN_G at 52;
  - remains in MAIN_G thereafter.
- Pedestrian: no side_req; single ped_req pulse at cycle 50.
  - ped_pending=1 over cycles 51..63;
  - MAIN_Y at 52, ALL_R1 at 60, SIDE_G with walk=1 over 64..79;
  - ped_pending=0 from cycle 64.
- Ignored or coincident requests:
  - during the vehicle cycle, a ped_req at cycle 30 (SIDE_G) leaves ped_pending=0, and the block stays in MAIN_G after 52;
  - ped_req at cycle 23 (coincident with SIDE_G entry) also leaves ped_pending=0 at cycle 24.
- Mid-operation reset: rst high at cycle 44 (SIDE_Y) for one cycle → main_green=1 and phase=0 at cycle 45, ped_pending=0.
  - With side_req held high, the next MAIN_Y appears 12 cycles after reset release.
- Safety monitor, active in all scenarios: a lit green or yellow on both roads at once, or more than one lamp per road, is a fail.

Source files
------------

// File: rtl/intersection_ctrl_if.sv
// Lamp/request bundle between the intersection sequencer and the roadside I/O.
// The master side is the sequencer: it reads the sensors and drives the lamps.
interface intersection_ctrl_if;
    logic       side_req;
    logic       ped_req;
    logic       main_green;
    logic       main_yellow;
    logic       main_red;
    logic       side_green;
    logic       side_yellow;
    logic       side_red;
    logic       walk;
    logic       ped_pending;
    logic [2:0] phase;

    modport master (
        input  side_req, ped_req,
        output main_green, main_yellow, main_red,
        output side_green, side_yellow, side_red,
        output walk, ped_pending, phase
    );

    modport slave (
        output side_req, ped_req,
        input  main_green, main_yellow, main_red,
        input  side_green, side_yellow, side_red,
        input  walk, ped_pending, phase
    );
endinterface

// File: rtl/intersection_ctrl.sv
// Two-road phase sequencer: tick prescaler + per-phase tick timer, Moore lamp decode.
// Lamps change one cycle after the deciding tick; no backpressure, requests are level/latched.
module intersection_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int T_MG_MIN = 30,
    parameter int T_Y      = 3,
    parameter int T_AR     = 2,
    parameter int T_SG     = 15
) (
    input  logic                clk,
    input  logic                rst,
    intersection_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        MAIN_G = 3'd0,
        MAIN_Y = 3'd1,
        ALL_R1 = 3'd2,
        SIDE_G = 3'd3,
        SIDE_Y = 3'd4,
        ALL_R2 = 3'd5
    } state_t;

    localparam int CW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int T_M1  = (T_MG_MIN > T_SG) ? T_MG_MIN : T_SG;
    localparam int T_M2  = (T_Y > T_AR) ? T_Y : T_AR;
    localparam int T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [TW-1:0] MG_LAST  = TW'(T_MG_MIN - 1);
    localparam logic [TW-1:0] Y_LAST   = TW'(T_Y - 1);
    localparam logic [TW-1:0] AR_LAST  = TW'(T_AR - 1);
    localparam logic [TW-1:0] SG_LAST  = TW'(T_SG - 1);

    logic [CW-1:0] cnt;
    logic          tick;
    logic [TW-1:0] tmr;
    logic          ped_q;
    state_t        state_q;
    state_t        state_d;

    assign tick = (cnt == CNT_LAST);

    // Prescaler is free-running so phase boundaries stay tick-aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MAIN_G: if (tick && tmr == MG_LAST && (bus.side_req || ped_q)) state_d = MAIN_Y;
            MAIN_Y: if (tick && tmr == Y_LAST)  state_d = ALL_R1;
            ALL_R1: if (tick && tmr == AR_LAST) state_d = SIDE_G;
            SIDE_G: if (tick && tmr == SG_LAST) state_d = SIDE_Y;
            SIDE_Y: if (tick && tmr == Y_LAST)  state_d = ALL_R2;
            ALL_R2: if (tick && tmr == AR_LAST) state_d = MAIN_G;
            default: state_d = ALL_R2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MAIN_G;
        end else begin
            state_q <= state_d;
        end
    end

    // Main green parks at its last count so a late request needs only the next tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr <= '0;
        end else if (state_d != state_q) begin
            tmr <= '0;
        end else if (tick && !(state_q == MAIN_G && tmr == MG_LAST)) begin
            tmr <= tmr + TW'(1);
        end
    end

    // Entering SIDE_G serves the request, so the clear beats a coincident press.
    always_ff @(posedge clk) begin
        if (rst) begin
            ped_q <= 1'b0;
        end else if (state_d == SIDE_G && state_q != SIDE_G) begin
            ped_q <= 1'b0;
        end else if (bus.ped_req && state_q != SIDE_G) begin
            ped_q <= 1'b1;
        end
    end

    assign bus.main_green  = (state_q == MAIN_G);
    assign bus.main_yellow = (state_q == MAIN_Y);
    assign bus.main_red    = !(state_q == MAIN_G || state_q == MAIN_Y);
    assign bus.side_green  = (state_q == SIDE_G);
    assign bus.side_yellow = (state_q == SIDE_Y);
    assign bus.side_red    = !(state_q == SIDE_G || state_q == SIDE_Y);
    assign bus.walk        = (state_q == SIDE_G);
    assign bus.ped_pending = ped_q;
    assign bus.phase       = state_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Bench for intersection_ctrl: directed timing scenarios plus random traffic against a
// duration-based reference model of the phase sequence.
module tb_intersection_ctrl;

    localparam int TD  = 4;
    localparam int TMG = 3;
    localparam int TY  = 2;
    localparam int TAR = 1;
    localparam int TSG = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    intersection_ctrl_if bus ();

    intersection_ctrl #(
        .TICK_DIV(TD), .T_MG_MIN(TMG), .T_Y(TY), .T_AR(TAR), .T_SG(TSG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] dut_lamps;
    assign dut_lamps = {bus.main_green, bus.main_yellow, bus.main_red,
                        bus.side_green, bus.side_yellow, bus.side_red, bus.walk};

    // Reference model: phases last dur*TD cycles from their entry cycle; main green
    // leaves on the first tick at or after its minimum time with a request present.
    int   m_phase   = 0;
    int   m_cyc     = 0;
    int   m_entered = 0;
    logic m_pend    = 1'b0;
    logic m_tick;
    logic m_adv;
    int   m_el;
    int   m_next;

    function automatic int dur_of(int p);
        case (p)
            1, 4:    return TY;
            2, 5:    return TAR;
            3:       return TSG;
            default: return TMG;
        endcase
    endfunction

    function automatic logic [6:0] lamps_of(int p);
        return {p == 0, p == 1, p > 1, p == 3, p == 4, !(p == 3 || p == 4), p == 3};
    endfunction

    // Expected phase when main leaves green at cycle s (yellow 8, all-red 4, side green 16).
    function automatic int exp_phase(int c, int s);
        if (c < s)      return 0;
        if (c < s + 8)  return 1;
        if (c < s + 12) return 2;
        if (c < s + 28) return 3;
        if (c < s + 36) return 4;
        if (c < s + 40) return 5;
        return 0;
    endfunction

    always_comb begin
        m_tick = ((m_cyc % TD) == TD - 1);
        m_el   = m_cyc - m_entered + 1;
        if (m_phase == 0) m_adv = m_tick && (m_el >= TMG * TD) && (bus.side_req || m_pend);
        else              m_adv = (m_el == dur_of(m_phase) * TD);
        m_next = m_adv ? ((m_phase + 1) % 6) : m_phase;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_phase   <= 0;
            m_cyc     <= 0;
            m_entered <= 0;
            m_pend    <= 1'b0;
        end else begin
            m_phase <= m_next;
            m_cyc   <= m_cyc + 1;
            if (m_adv) m_entered <= m_cyc + 1;
            if (m_adv && m_next == 3)           m_pend <= 1'b0;
            else if (bus.ped_req && m_phase != 3) m_pend <= 1'b1;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.side_req = 1'b0;
        bus.ped_req  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (dut_lamps !== 7'b1000010) begin
                n_fail++;
                $display("FAIL reset_lamps cyc=%0d got=%b required=%b", c, dut_lamps, 7'b1000010);
            end
            n_checks++;
            if (bus.ped_pending !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_pending cyc=%0d got=%b required=0", c, bus.ped_pending);
            end
            n_checks++;
            if (bus.phase !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_phase cyc=%0d got=%0d required=0", c, bus.phase);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_idle();
        do_reset();
        for (int c = 0; c < 1000; c++) begin
            n_checks++;
            if (bus.phase !== 3'd0 || dut_lamps !== 7'b1000010) begin
                n_fail++;
                $display("FAIL idle cyc=%0d phase=%0d lamps=%b required phase=0 lamps=1000010",
                         c, bus.phase, dut_lamps);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_vehicle();
        do_reset();
        for (int c = 0; c < 120; c++) begin
            bus.side_req = (c <= 23);
            bus.ped_req  = (c == 23 || c == 30);
            n_checks++;
            if (bus.phase !== 3'(exp_phase(c, 12))) begin
                n_fail++;
                $display("FAIL vehicle_phase cyc=%0d got=%0d required=%0d", c, bus.phase, exp_phase(c, 12));
            end
            n_checks++;
            if (bus.ped_pending !== 1'b0) begin
                n_fail++;
                $display("FAIL vehicle_ignored_ped cyc=%0d pending=%b required=0", c, bus.ped_pending);
            end
            n_checks++;
            if (dut_lamps !== lamps_of(m_phase)) begin
                n_fail++;
                $display("FAIL vehicle_lamps cyc=%0d got=%b required=%b", c, dut_lamps, lamps_of(m_phase));
            end
            n_checks++;
            if ($countones(dut_lamps[6:4]) != 1 || $countones(dut_lamps[3:1]) != 1 ||
                (!bus.main_red && !bus.side_red)) begin
                n_fail++;
                $display("FAIL safety_vehicle cyc=%0d lamps=%b required one lamp per road, one road red", c, dut_lamps);
            end
            @(negedge clk);
        end
        bus.ped_req = 1'b0;
    endtask

    task automatic test_ped();
        do_reset();
        for (int c = 0; c < 110; c++) begin
            bus.ped_req = (c == 50);
            n_checks++;
            if (bus.phase !== 3'(exp_phase(c, 52))) begin
                n_fail++;
                $display("FAIL ped_phase cyc=%0d got=%0d required=%0d", c, bus.phase, exp_phase(c, 52));
            end
            n_checks++;
            if (bus.ped_pending !== (c >= 51 && c <= 63)) begin
                n_fail++;
                $display("FAIL ped_pending cyc=%0d got=%b required=%b", c, bus.ped_pending, (c >= 51 && c <= 63));
            end
            n_checks++;
            if (bus.walk !== (c >= 64 && c <= 79)) begin
                n_fail++;
                $display("FAIL ped_walk cyc=%0d got=%b required=%b", c, bus.walk, (c >= 64 && c <= 79));
            end
            n_checks++;
            if ($countones(dut_lamps[6:4]) != 1 || $countones(dut_lamps[3:1]) != 1 ||
                (!bus.main_red && !bus.side_red)) begin
                n_fail++;
                $display("FAIL safety_ped cyc=%0d lamps=%b required one lamp per road, one road red", c, dut_lamps);
            end
            @(negedge clk);
        end
        bus.ped_req = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int c = 0; c < 70; c++) begin
            bus.side_req = 1'b1;
            bus.ped_req  = (c == 42);
            rst          = (c == 44);
            if (c == 43) begin
                n_checks++;
                if (bus.ped_pending !== 1'b1 || bus.phase !== 3'd4) begin
                    n_fail++;
                    $display("FAIL midrst_before cyc=%0d pending=%b phase=%0d required pending=1 phase=4",
                             c, bus.ped_pending, bus.phase);
                end
            end
            if (c == 45) begin
                n_checks++;
                if (bus.main_green !== 1'b1 || bus.phase !== 3'd0 || bus.ped_pending !== 1'b0) begin
                    n_fail++;
                    $display("FAIL midrst_after cyc=%0d main_green=%b phase=%0d pending=%b required 1/0/0",
                             c, bus.main_green, bus.phase, bus.ped_pending);
                end
            end
            if (c == 56 || c == 57) begin
                n_checks++;
                if (bus.phase !== ((c == 57) ? 3'd1 : 3'd0)) begin
                    n_fail++;
                    $display("FAIL midrst_yellow cyc=%0d phase=%0d required=%0d", c, bus.phase, (c == 57) ? 1 : 0);
                end
            end
            n_checks++;
            if (bus.phase !== 3'(m_phase) || bus.ped_pending !== m_pend) begin
                n_fail++;
                $display("FAIL midrst_model cyc=%0d phase=%0d pending=%b required phase=%0d pending=%b",
                         c, bus.phase, bus.ped_pending, m_phase, m_pend);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        bus.side_req = 1'b0;
        bus.ped_req  = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(39) == 0) bus.side_req = ~bus.side_req;
            bus.ped_req = ($urandom_range(59) == 0);
            rst         = ($urandom_range(799) == 0);
            n_checks++;
            if (bus.phase !== 3'(m_phase)) begin
                n_fail++;
                $display("FAIL rand_phase cyc=%0d got=%0d required=%0d", c, bus.phase, m_phase);
            end
            n_checks++;
            if (bus.ped_pending !== m_pend) begin
                n_fail++;
                $display("FAIL rand_pending cyc=%0d got=%b required=%b", c, bus.ped_pending, m_pend);
            end
            n_checks++;
            if (dut_lamps !== lamps_of(m_phase)) begin
                n_fail++;
                $display("FAIL rand_lamps cyc=%0d got=%b required=%b", c, dut_lamps, lamps_of(m_phase));
            end
            n_checks++;
            if ($countones(dut_lamps[6:4]) != 1 || $countones(dut_lamps[3:1]) != 1 ||
                (!bus.main_red && !bus.side_red)) begin
                n_fail++;
                $display("FAIL safety_rand cyc=%0d lamps=%b required one lamp per road, one road red", c, dut_lamps);
            end
            @(negedge clk);
        end
        rst          = 1'b0;
        bus.side_req = 1'b0;
        bus.ped_req  = 1'b0;
    endtask

    initial begin
        bus.side_req = 1'b0;
        bus.ped_req  = 1'b0;
        test_reset();
        test_idle();
        test_vehicle();
        test_ped();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
